// File: rtl/parameter_stream_sink_pkg.sv
// Shared types and helpers for the parameter streaming sink.
// Holds the sink FSM state encoding and the packed-beat width helper.
package param_stream_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } sink_state_t;

    function automatic int beat_width(input int prec, input int par0, input int par1);
        return prec * par0 * par1;
    endfunction

endpackage

// File: rtl/parameter_stream_sink_ram.sv
// Simple dual-port frame RAM: one write port, one ROM-style read port with a
// two-stage ce-gated read pipeline. Out-of-range reads return zero.
module param_sink_ram
    import param_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 6,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ce_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] q_q;
    logic             in_range_s;

    assign in_range_s = (raddr_i < AW'(DEPTH));
    assign q_o        = q_q;

    // Write port; contents survive reset so a held frame stays readable.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read pipeline: nonblocking read of mem gives read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage1_q <= '0;
            q_q      <= '0;
        end else if (ce_i) begin
            stage1_q <= in_range_s ? mem[raddr_i[IDX_W-1:0]] : '0;
            q_q      <= stage1_q;
        end
    end

endmodule

// File: rtl/parameter_stream_sink.sv
// Parameter stream sink: captures one streamed frame into RAM, then holds it for
// ROM-style readback. Optional frame XOR checksum under `PARAM_SINK_CHECKSUM_EN.
module parameter_stream_sink
    import param_stream_pkg::*;
#(
    parameter int PRECISION_0       = 16,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int IN_DEPTH          = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    parameter int ADDR_WIDTH        = $clog2(IN_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PRECISION_0-1:0] data_in [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic                   frame_release,
    output logic                   frame_done,
    input  logic [ADDR_WIDTH-1:0]  address0,
    input  logic                   ce0,
    output logic [PRECISION_0*PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0] q0
`ifdef PARAM_SINK_CHECKSUM_EN
    ,
    output logic [PRECISION_0*PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0] checksum
`endif
);

    localparam int P      = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int BEAT_W = beat_width(PRECISION_0, PARALLELISM_DIM_0, PARALLELISM_DIM_1);
    localparam int IDX_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    sink_state_t       state_q, state_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              frame_done_q, frame_done_d;
    logic [BEAT_W-1:0] beat_s;
    logic              accept_s;
    logic              last_s;

    // Ready is a pure decode of the registered state.
    assign data_in_ready = (state_q == FILL);
    assign accept_s      = data_in_valid && (state_q == FILL);
    assign last_s        = (wr_ptr_q == IDX_W'(IN_DEPTH - 1));
    assign frame_done    = frame_done_q;

    // Pack beat elements, element j at bit offset PRECISION_0*j.
    always_comb begin
        beat_s = '0;
        for (int j = 0; j < P; j++) begin
            beat_s[PRECISION_0*j +: PRECISION_0] = data_in[j];
        end
    end

    // Next-state logic for the fill/hold FSM and write pointer.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        frame_done_d = 1'b0;
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    if (last_s) begin
                        wr_ptr_d     = '0;
                        state_d      = HOLD;
                        frame_done_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + IDX_W'(1);
                    end
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
            end
            HOLD: begin
                if (frame_release) begin
                    state_d = FILL;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d  = FILL;
                wr_ptr_d = '0;
            end
        endcase
    end

    // State, pointer and completion pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef PARAM_SINK_CHECKSUM_EN
    logic [BEAT_W-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0] checksum_q, checksum_d;

    assign checksum = checksum_q;

    // Running XOR; published and cleared on the final beat so it lines up with frame_done.
    always_comb begin
        acc_d      = acc_q;
        checksum_d = checksum_q;
        if (accept_s) begin
            if (last_s) begin
                checksum_d = acc_q ^ beat_s;
                acc_d      = '0;
            end else begin
                acc_d = acc_q ^ beat_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q      <= '0;
            checksum_q <= '0;
        end else begin
            acc_q      <= acc_d;
            checksum_q <= checksum_d;
        end
    end
`endif

    param_sink_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (IN_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (beat_s),
        .ce_i    (ce0),
        .raddr_i (address0),
        .q_o     (q0)
    );

endmodule

// File: tb/tb_parameter_stream_sink.sv
// Directed self-checking bench for parameter_stream_sink (default 16-bit, 32-entry build).
module tb_parameter_stream_sink;

    logic        clk;
    logic        rst;
    logic [15:0] data_in [1];
    logic        data_in_valid;
    logic        data_in_ready;
    logic        frame_release;
    logic        frame_done;
    logic [5:0]  address0;
    logic        ce0;
    logic [15:0] q0;
`ifdef PARAM_SINK_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int n_cmp;
    int n_bad;

    parameter_stream_sink dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .frame_release (frame_release),
        .frame_done    (frame_done),
        .address0      (address0),
        .ce0           (ce0),
        .q0            (q0)
`ifdef PARAM_SINK_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream_beat(input logic [15:0] val);
        data_in[0]    = val;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [5:0] addr, input logic [15:0] exp);
        address0 = addr;
        ce0      = 1'b1;
        tick();
        tick();
        check_val(tag, {16'h0, q0}, {16'h0, exp});
        ce0 = 1'b0;
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
    endtask

    int  accepts;
    bit  early_done;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        data_in[0] = 16'h0;
        data_in_valid = 1'b0;
        frame_release = 1'b0;
        address0 = 6'd0;
        ce0 = 1'b1;
        tick();
        tick();
        check_val("rst_q0", {16'h0, q0}, 32'h0);
        check_val("rst_done", {31'h0, frame_done}, 32'h0);
`ifdef PARAM_SINK_CHECKSUM_EN
        check_val("rst_checksum", {16'h0, checksum}, 32'h0);
`endif
        ce0 = 1'b0;
        rst = 1'b1;
        check_val("rst_ready", {31'h0, data_in_ready}, 32'h1);

        // Frame 0..31 back to back.
        accepts = 0;
        early_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (data_in_ready) accepts++;
            stream_beat(16'(i));
            if (i < 31 && frame_done) early_done = 1'b1;
        end
        check_val("f1_accepts", 32'(accepts), 32'd32);
        check_val("f1_early_done", {31'h0, early_done}, 32'h0);
        check_val("f1_done", {31'h0, frame_done}, 32'h1);
        check_val("f1_ready_hold", {31'h0, data_in_ready}, 32'h0);
`ifdef PARAM_SINK_CHECKSUM_EN
        check_val("f1_checksum", {16'h0, checksum}, 32'h0);
`endif
        tick();
        check_val("f1_done_pulse", {31'h0, frame_done}, 32'h0);

        read_check("f1_rd0", 6'd0, 16'd0);
        read_check("f1_rd5", 6'd5, 16'd5);
        read_check("f1_rd31", 6'd31, 16'd31);
        read_check("f1_rd32_oor", 6'd32, 16'd0);
        read_check("f1_rd7", 6'd7, 16'd7);

        // Beat offered while holding must be ignored.
        data_in[0] = 16'hBEEF;
        data_in_valid = 1'b1;
        repeat (3) tick();
        check_val("hold_ready", {31'h0, data_in_ready}, 32'h0);
        check_val("hold_done", {31'h0, frame_done}, 32'h0);
        data_in_valid = 1'b0;
        read_check("hold_nowrite", 6'd0, 16'd0);

        release_frame();
        check_val("rel_ready", {31'h0, data_in_ready}, 32'h1);

        // Frame 100..131 with idle gaps.
        for (int i = 0; i < 32; i++) begin
            stream_beat(16'(100 + i));
            if (i % 5 == 2) repeat (2) tick();
        end
        check_val("f2_done", {31'h0, frame_done}, 32'h1);
        read_check("f2_rd0", 6'd0, 16'd100);
        read_check("f2_rd17", 6'd17, 16'd117);
        read_check("f2_rd31", 6'd31, 16'd131);

        // ce0 freeze mid-read.
        address0 = 6'd3;
        ce0 = 1'b1;
        tick();
        address0 = 6'd4;
        tick();
        check_val("ce_pre", {16'h0, q0}, 32'd103);
        ce0 = 1'b0;
        address0 = 6'd9;
        repeat (3) tick();
        check_val("ce_frozen", {16'h0, q0}, 32'd103);
        ce0 = 1'b1;
        tick();
        check_val("ce_resume1", {16'h0, q0}, 32'd104);
        tick();
        check_val("ce_resume2", {16'h0, q0}, 32'd109);
        ce0 = 1'b0;

        // Reset mid-frame after 10 beats.
        release_frame();
        for (int i = 0; i < 10; i++) stream_beat(16'(200 + i));
        rst = 1'b0;
        tick();
        check_val("mid_rst_q0", {16'h0, q0}, 32'h0);
        check_val("mid_rst_done", {31'h0, frame_done}, 32'h0);
        rst = 1'b1;
        check_val("mid_rst_ready", {31'h0, data_in_ready}, 32'h1);
        early_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
            stream_beat(16'(300 + i));
            if (i < 31 && frame_done) early_done = 1'b1;
        end
        check_val("f3_early_done", {31'h0, early_done}, 32'h0);
        check_val("f3_done", {31'h0, frame_done}, 32'h1);
        read_check("f3_rd0", 6'd0, 16'd300);
        read_check("f3_rd9", 6'd9, 16'd309);
        read_check("f3_rd20", 6'd20, 16'd320);

`ifdef PARAM_SINK_CHECKSUM_EN
        release_frame();
        for (int i = 0; i < 32; i++) stream_beat(16'h00A5);
        check_val("cs_a5_done", {31'h0, frame_done}, 32'h1);
        check_val("cs_a5", {16'h0, checksum}, 32'h0);
        release_frame();
        for (int i = 0; i < 32; i++) stream_beat((i == 7) ? 16'h1234 : 16'h0000);
        check_val("cs_1234", {16'h0, checksum}, 32'h1234);
        tick();
        check_val("cs_hold", {16'h0, checksum}, 32'h1234);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
